// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI transmit path.
// Pure declarations; no logic, no latency, no backpressure.
package spi_pkg;

    localparam int SPI_Q_DEPTH   = 8;
    localparam int SPI_Q_TIMEOUT = 4096;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;
    localparam logic [1:0] ST_GAP      = 2'd3;

endpackage

// File: rtl/spi_sync_fifo.sv
// Byte FIFO with registered full/empty/level; head byte visible combinationally on pop_data.
// Push lands 1 cycle later; push while full and pop while empty are ignored.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = SPI_Q_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (push_ok && !pop_ok)
            level_nxt = level + LVL_ONE;
        else if (!push_ok && pop_ok)
            level_nxt = level - LVL_ONE;
    end

    // Storage carries no reset; a flush only needs the pointers and level cleared.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            level <= level_nxt;
            full  <= (level_nxt == LVL_MAX);
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/spi_tx_queue.sv
// Byte queue feeding the SPI sender one byte per start/rdy handshake, with timeout guard.
// Write to tx_start is 2 cycles; holds in IDLE while tx_busy, drops writes when full.
module spi_tx_queue
    import spi_pkg::*;
#(
    parameter int DEPTH   = SPI_Q_DEPTH,
    parameter int TIMEOUT = SPI_Q_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_rdy,
    input  logic                     tx_busy,
    output logic                     done,
    output logic                     overflow,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    head;
    logic          issue;
    logic          timeout_hit;
    logic          wait_end;

    assign issue       = (state == ST_IDLE) && !empty && !tx_busy;
    assign timeout_hit = (state == ST_WAIT_RDY) && !tx_rdy && (cnt == CNT_LAST);
    assign wait_end    = (state == ST_WAIT_RDY) && (tx_rdy || (cnt == CNT_LAST));

    spi_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (issue),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        tx_data  <= head;
                        tx_start <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (wait_end) begin
                        // No pop happens here, so the queue is empty in GAP only if
                        // it is empty now and nothing is written this cycle.
                        done  <= empty & ~wr_en;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: doc/spi_tx_queue.md
# spi_tx_queue

Byte queue and issue controller directly upstream of the SPI byte sender. It buffers bytes written by the host logic in a small FIFO and feeds them to the sender one at a time over the sender's `start`/`data`/`rdy`/`mutex` handshake. It also guards each transfer with a timeout and reports overflow and drain events.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, ≥2.
- `TIMEOUT`, 4096: max cycles in WAIT_RDY before abort; ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  FIFO full, registered.
- `empty`  out  1  FIFO empty, registered.
- `level`  out  $clog2(DEPTH)+1  bytes currently queued.
- `tx_data`  out  8  byte to sender; valid while `tx_start`=1.
- `tx_start`  out  1  one-cycle start pulse to sender.
- `tx_rdy`  in  1  sender byte-complete pulse.
- `tx_busy`  in  1  sender mutex; high while the sender owns the bus.
- `done`  out  1  one-cycle pulse: last queued byte finished, FIFO empty.
- `overflow`  out  1  sticky: a write was dropped while full.
- `timeout_err`  out  1  sticky: a transfer exceeded TIMEOUT.
- `clr_err`  in  1  clears `overflow` and `timeout_err`.

## Operation
- Reset values: `full`=0, `empty`=1, `level`=0, `tx_data`=0x00, `tx_start`=0, `done`=0, `overflow`=0, `timeout_err`=0. FIFO pointers are 0 and the FSM is in IDLE.
- Write: accepted iff `wr_en`=1 and the registered `full`=0. On a write with `full`=1, the byte is dropped and `overflow` is set.
- Pop: occurs only on the IDLE→ISSUE edge.
- Simultaneous write and pop: both happen and `level` is unchanged.
- FSM states:
  - IDLE: if `empty`=0 and `tx_busy`=0, pop the head into `tx_data` and go to ISSUE.
  - ISSUE: `tx_start`=1 for exactly this cycle. Go to WAIT_RDY and clear the timeout counter.
  - WAIT_RDY: `tx_data` is held.
    - On `tx_rdy`=1, go to GAP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1, set `timeout_err` and go to GAP.
  - GAP: one cycle, which lets the sender return to its idle state. `done`=1 during GAP iff `empty`=1. Go to IDLE.
- A `tx_rdy` pulse outside WAIT_RDY is ignored.
- Error flags: `clr_err` clears both flags. If a flag is set and cleared in the same cycle, set wins.
- Reset mid-transfer: FIFO is flushed and `tx_start` is deasserted at once. The sender shares `rst`, so no partial byte resumes.
- Arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is $clog2(DEPTH)+1 bits, so `level`=DEPTH is representable.
  - `full` = (`level`==DEPTH); `empty` = (`level`==0).

## Timing
- `wr_en` in cycle 0 into an empty, idle queue:
  - `empty` falls in cycle 1.
  - `tx_start`=1 in cycle 2 with `tx_data` = that byte.
- `tx_rdy` in cycle k: GAP in cycle k+1; earliest next `tx_start` in cycle k+3.
- Steady-state overhead per byte: 3 cycles beyond the sender's own duration.
- `done` is asserted 1 cycle after the final `tx_rdy`.
- Timeout with no `tx_rdy` after ISSUE in cycle s:
  - `timeout_err` rises at cycle s+TIMEOUT+1.
  - FSM reaches IDLE at s+TIMEOUT+2.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `spi_pkg`:
  - FSM state encoding: IDLE, ISSUE, WAIT_RDY, GAP.
  - Default constants SPI_Q_DEPTH=8 and SPI_Q_TIMEOUT=4096.
- One sub-module, `spi_sync_fifo`: parameterised depth, 8-bit wide, registered `full`/`empty`/`level`, push/pop ports.
- FSM, timeout counter and error flags live in the top module.

## Test plan
- Single byte: write 0xA5 into an idle queue. Expect:
  - `tx_start` in cycle 2 with `tx_data`=0xA5.
  - Sender model returns `tx_rdy`; `done` pulses one cycle after it.
- Burst: write 0x01..0x08 back-to-back (`DEPTH`=8). Expect:
  - `full`=1 after the 8th write (if no pop has yet occurred).
  - Bytes issued in order 0x01..0x08, with exactly one `done`, after 0x08.
- Overflow: fill to 8 and write 0xFF while `full`. Expect:
  - `overflow`=1 and 0xFF is never issued.
  - `clr_err` clears the flag; `clr_err` together with another overflow write leaves `overflow`=1.
- Simultaneous push/pop: write in the IDLE→ISSUE cycle with `level`=3. Expect `level` to stay 3 and order to be preserved.
- Timeout (`TIMEOUT`=16): the sender model never pulses `tx_rdy`. Expect:
  - `timeout_err` at s+17.
  - The next queued byte is issued afterwards.
- Reset mid-WAIT_RDY with `level`=4: expect every output at its reset value on the next cycle and no `tx_start` until a new write.
